// File: rtl/risc_seq_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the 16-bit RISC datapath.
// The datapath/memory side (master) drives opcode, flags and acks; the sequencer (slave) drives enables.
interface risc_seq_ctrl_if;
  logic [3:0] opcode;
  logic       alu_zero;
  logic       imem_ack;
  logic       dmem_ack;
  logic       imem_req;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_src;
  logic [1:0] alu_op;
  logic       alu_src;
  logic       dmem_req;
  logic       dmem_we;
  logic       reg_we;
  logic       mem_to_reg;
  logic [2:0] state;
  logic [1:0] err_code;

  // A request (imem_req/dmem_req) is held high until the matching ack is seen
  // in a cycle; the transfer completes in exactly that cycle.
  modport master (
    output opcode, alu_zero, imem_ack, dmem_ack,
    input  imem_req, ir_we, pc_we, pc_src, alu_op, alu_src,
           dmem_req, dmem_we, reg_we, mem_to_reg, state, err_code
  );

  modport slave (
    input  opcode, alu_zero, imem_ack, dmem_ack,
    output imem_req, ir_we, pc_we, pc_src, alu_op, alu_src,
           dmem_req, dmem_we, reg_we, mem_to_reg, state, err_code
  );
endinterface

// File: rtl/risc_seq_ctrl.sv
// Multi-cycle control FSM for the 16-bit RISC core: fetch, decode, execute,
// memory and write-back, with a sticky error state for illegal opcodes and memory timeouts.
module risc_seq_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  risc_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] ALU_FUNC  = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_ADD   = 2'b10;
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ILL   = 2'b01;
  localparam logic [1:0] ERR_IMEM  = 2'b10;
  localparam logic [1:0] ERR_DMEM  = 2'b11;

  state_t          r_state;
  logic [TO_W-1:0] r_cnt;
  logic [1:0]      r_err;

  state_t          w_state_nxt;
  logic [TO_W-1:0] w_cnt_nxt;
  logic [1:0]      w_err_nxt;
  logic            w_waiting;
  logic            w_to_hit;

  logic w_is_ld, w_is_st, w_is_rtype, w_is_beq, w_is_bne, w_is_jmp, w_illegal;
  logic w_taken;

  assign w_is_ld    = (bus.opcode == 4'b0000);
  assign w_is_st    = (bus.opcode == 4'b0001);
  assign w_is_rtype = (bus.opcode >= 4'b0010) && (bus.opcode <= 4'b1001);
  assign w_is_beq   = (bus.opcode == 4'b1011);
  assign w_is_bne   = (bus.opcode == 4'b1100);
  assign w_is_jmp   = (bus.opcode == 4'b1101);
  assign w_illegal  = !(w_is_ld || w_is_st || w_is_rtype || w_is_beq || w_is_bne || w_is_jmp);
  assign w_taken    = (w_is_beq && bus.alu_zero) || (w_is_bne && !bus.alu_zero);

  // The ack in the cycle where cnt reaches MEM_TIMEOUT still wins over the timeout.
  assign w_to_hit = (MEM_TIMEOUT != 0) && (r_cnt == TO_W'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_err   <= ERR_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_waiting   = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (bus.imem_ack) begin
          w_state_nxt = S_DECODE;
        end else if (w_to_hit) begin
          w_state_nxt = S_ERROR;
          w_err_nxt   = ERR_IMEM;
        end else begin
          w_waiting = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_illegal) begin
          w_state_nxt = S_ERROR;
          w_err_nxt   = ERR_ILL;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_is_ld || w_is_st) begin
          w_state_nxt = S_MEM;
        end else if (w_is_rtype) begin
          w_state_nxt = S_WB;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          w_state_nxt = w_is_ld ? S_WB : S_FETCH;
        end else if (w_to_hit) begin
          w_state_nxt = S_ERROR;
          w_err_nxt   = ERR_DMEM;
        end else begin
          w_waiting = 1'b1;
        end
      end
      S_WB:    w_state_nxt = S_FETCH;
      S_ERROR: w_state_nxt = S_ERROR;
      default: w_state_nxt = S_FETCH;
    endcase

    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if (w_waiting) begin
      w_cnt_nxt = r_cnt + TO_W'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Write strobes are masked by rst_n so an instruction abandoned by reset
  // never commits IR, PC, register or memory state on the reset edge.
  always_comb begin
    bus.imem_req   = 1'b0;
    bus.ir_we      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.pc_src     = PC_SEQ;
    bus.alu_op     = ALU_FUNC;
    bus.alu_src    = 1'b0;
    bus.dmem_req   = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.reg_we     = 1'b0;
    bus.mem_to_reg = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_we    = bus.imem_ack && rst_n;
      end
      S_EXEC: begin
        if (w_is_ld || w_is_st) begin
          bus.alu_op  = ALU_ADD;
          bus.alu_src = 1'b1;
        end else if (w_is_beq || w_is_bne) begin
          bus.alu_op = ALU_SUB;
          bus.pc_we  = rst_n;
          bus.pc_src = w_taken ? PC_BRANCH : PC_SEQ;
        end else if (w_is_jmp) begin
          bus.pc_we  = rst_n;
          bus.pc_src = PC_JUMP;
        end
      end
      S_MEM: begin
        bus.alu_op   = ALU_ADD;
        bus.alu_src  = 1'b1;
        bus.dmem_req = 1'b1;
        bus.dmem_we  = w_is_st && rst_n;
        bus.pc_we    = w_is_st && bus.dmem_ack && rst_n;
      end
      S_WB: begin
        bus.reg_we     = rst_n;
        bus.mem_to_reg = w_is_ld;
        bus.pc_we      = rst_n;
      end
      default: ;
    endcase
  end

  assign bus.state    = r_state;
  assign bus.err_code = r_err;

endmodule

// File: tb/tb_risc_seq_ctrl.sv
// Randomized cycle-accurate check of risc_seq_ctrl against a per-instruction
// reference trace built from the opcode map, latencies and timeout rules.
module tb_risc_seq_ctrl;
  localparam int TO = 15;
  localparam int ERR_CYC = 20;

  logic clk;
  logic rst_n;
  risc_seq_ctrl_if bus ();

  risc_seq_ctrl #(.MEM_TIMEOUT(TO), .TO_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard: one expected output vector and one ack pair per cycle
  logic [16:0] exp_q[$];
  logic [1:0]  ack_q[$];
  bit          exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] obs();
    return {bus.state, bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_src, bus.alu_op,
            bus.alu_src, bus.dmem_req, bus.dmem_we, bus.reg_we, bus.mem_to_reg, bus.err_code};
  endfunction

  function automatic logic [16:0] mk(input logic [2:0] st, input logic ireq, input logic irw,
                                     input logic pcw, input logic [1:0] pcs, input logic [1:0] aop,
                                     input logic asrc, input logic dreq, input logic dwe,
                                     input logic rwe, input logic m2r, input logic [1:0] err);
    return {st, ireq, irw, pcw, pcs, aop, asrc, dreq, dwe, rwe, m2r, err};
  endfunction

  task automatic push(input logic [16:0] rec, input logic [1:0] ack);
    exp_q.push_back(rec);
    ack_q.push_back(ack);
  endtask

  task automatic err_tail(input logic [1:0] e);
    for (int k = 0; k < ERR_CYC; k++) push(mk(3'd7, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, e), 2'b00);
    exp_err = 1'b1;
  endtask

  // reference: whole-instruction trace from the opcode class and wait counts
  task automatic build(input logic [3:0] op, input logic z, input int iw, input int dw);
    bit is_ld, is_st, is_br, taken;
    exp_err = 1'b0;
    is_ld = (op == 4'd0);
    is_st = (op == 4'd1);
    is_br = (op == 4'd11) || (op == 4'd12);
    taken = (op == 4'd11) ? z : !z;
    if (iw > TO) begin
      for (int k = 0; k <= TO; k++) push(mk(3'd0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00), 2'b00);
      err_tail(2'b10);
      return;
    end
    for (int k = 0; k < iw; k++) push(mk(3'd0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00), 2'b00);
    push(mk(3'd0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00), 2'b10);
    push(mk(3'd1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00), 2'b00);
    if (op == 4'd10 || op == 4'd14 || op == 4'd15) begin
      err_tail(2'b01);
    end else if (is_br) begin
      push(mk(3'd2, 0, 0, 1, taken ? 2'b01 : 2'b00, 2'b01, 0, 0, 0, 0, 0, 2'b00), 2'b00);
    end else if (op == 4'd13) begin
      push(mk(3'd2, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 2'b00), 2'b00);
    end else if (is_ld || is_st) begin
      push(mk(3'd2, 0, 0, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 2'b00), 2'b00);
      if (dw > TO) begin
        for (int k = 0; k <= TO; k++) push(mk(3'd3, 0, 0, 0, 2'b00, 2'b10, 1, 1, is_st, 0, 0, 2'b00), 2'b00);
        err_tail(2'b11);
      end else begin
        for (int k = 0; k < dw; k++) push(mk(3'd3, 0, 0, 0, 2'b00, 2'b10, 1, 1, is_st, 0, 0, 2'b00), 2'b00);
        push(mk(3'd3, 0, 0, is_st, 2'b00, 2'b10, 1, 1, is_st, 0, 0, 2'b00), 2'b01);
        if (is_ld) push(mk(3'd4, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 1, 1, 2'b00), 2'b00);
      end
    end else begin
      push(mk(3'd2, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00), 2'b00);
      push(mk(3'd4, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 1, 0, 2'b00), 2'b00);
    end
  endtask

  // reset pulse of one edge, then check the post-reset state
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    check({tag, "_state"}, 32'(bus.state), 32'd0);
    check({tag, "_err"}, 32'(bus.err_code), 32'd0);
    check({tag, "_ireq"}, 32'(bus.imem_req), 32'd1);
  endtask

  // driver: entered 1 time unit after a rising edge
  task automatic run(input string name, input logic [3:0] op, input logic z,
                     input int iw, input int dw, input int abort_at);
    logic [16:0] rec;
    logic [1:0]  ack;
    int i;
    bus.opcode   = op;
    bus.alu_zero = z;
    build(op, z, iw, dw);
    i = 0;
    while (exp_q.size() > 0) begin
      rec = exp_q.pop_front();
      ack = ack_q.pop_front();
      if (i == abort_at) begin
        rst_n = 1'b0;
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        check({name, "_rst_pcwe"}, 32'(bus.pc_we), 32'd0);
        check({name, "_rst_regwe"}, 32'(bus.reg_we), 32'd0);
        exp_q.delete();
        ack_q.delete();
        @(posedge clk); #1;
        do_reset({name, "_abort"});
        return;
      end
      bus.imem_ack = ack[1];
      bus.dmem_ack = ack[0];
      @(negedge clk);
      check($sformatf("%s_cyc%0d", name, i), 32'(obs()), 32'(rec));
      @(posedge clk); #1;
      i++;
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    if (exp_err) do_reset({name, "_err_rst"});
  endtask

  initial begin
    logic [3:0] op;
    int iw, dw;
    rst_n = 1'b0;
    bus.opcode   = 4'd0;
    bus.alu_zero = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    @(posedge clk); #1;
    do_reset("reset");

    run("add",      4'b0010, 1'b0, 0, 0, -1);
    run("ld_d3",    4'b0000, 1'b0, 0, 3, -1);
    run("st",       4'b0001, 1'b0, 0, 0, -1);
    run("beq_t",    4'b1011, 1'b1, 0, 0, -1);
    run("beq_nt",   4'b1011, 1'b0, 0, 0, -1);
    run("bne_t",    4'b1100, 1'b0, 0, 0, -1);
    run("bne_nt",   4'b1100, 1'b1, 0, 0, -1);
    run("jmp",      4'b1101, 1'b0, 1, 0, -1);
    run("ill_e",    4'b1110, 1'b0, 0, 0, -1);
    run("ill_a",    4'b1010, 1'b1, 2, 0, -1);
    run("imem_to",  4'b0011, 1'b0, 16, 0, -1);
    run("imem_15",  4'b1001, 1'b0, 15, 0, -1);
    run("dmem_to",  4'b0000, 1'b0, 0, 16, -1);
    run("st_15",    4'b0001, 1'b0, 0, 15, -1);
    run("st_abort", 4'b0001, 1'b0, 0, 5, 4);
    run("add_post", 4'b0100, 1'b1, 0, 0, -1);

    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      iw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 16) : $urandom_range(0, 2);
      dw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 16) : $urandom_range(0, 3);
      run($sformatf("rnd%0d_op%0d", n, op), op, 1'($urandom_range(0, 1)), iw, dw, -1);
    end

    @(negedge clk);
    check("final_state", 32'(bus.state), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/risc_seq_ctrl.md
Name: risc_seq_ctrl

Overview:
- Multi-cycle control FSM for the 16-bit RISC core.
- Sequences fetch, decode, execute, memory and write-back for each instruction.
- Drives the 2-bit ALUOp consumed by the ALU control unit, plus the PC, IR, register-file and memory enables.
- Handshakes with instruction and data memory; traps illegal opcodes and memory timeouts into a sticky error state.

Parameters:
- MEM_TIMEOUT, 15: maximum extra wait cycles for imem_ack/dmem_ack before error; 0 disables the timeout.
- TO_W, 4: width of the timeout counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opcode  in  4  IR[15:12]; stable from DECODE until the next FETCH.
- alu_zero  in  1  ALU zero flag, valid in EXEC.
- imem_ack  in  1  instruction memory data valid.
- dmem_ack  in  1  data memory access complete / read data valid.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  IR load strobe.
- pc_we  out  1  PC update strobe.
- pc_src  out  2  00 = PC+2, 01 = branch target, 10 = jump target.
- alu_op  out  2  to ALU control: 00 = by opcode, 01 = subtract (compare), 10 = add (address).
- alu_src  out  1  0 = register operand B, 1 = sign-extended immediate.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (store).
- reg_we  out  1  register file write enable.
- mem_to_reg  out  1  write-back mux select: 1 = memory data, 0 = ALU result.
- state  out  3  current state, for debug.
- err_code  out  2  00 = none, 01 = illegal opcode, 10 = imem timeout, 11 = dmem timeout.

Behaviour:
- Opcode map:
  - 0000 LD, 0001 ST.
  - 0010–1001 R-type ALU ops.
  - 1011 BEQ, 1100 BNE, 1101 JMP.
  - 1010, 1110, 1111 illegal.
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, ERROR = 7. Codes 5 and 6 are unreachable and recover to FETCH.
- Reset: the edge with rst_n = 0 sets state = FETCH, cnt = 0, err_code = 00. Reset mid-instruction abandons it; no strobes are issued on that edge.
- Outputs are decoded from the registered state; ir_we and pc_we are additionally qualified by ack where noted. Any output not listed for a state is 0.
- FETCH:
  - imem_req = 1.
  - On imem_ack: ir_we = 1 in the same cycle, go to DECODE.
  - Else if MEM_TIMEOUT != 0 and cnt == MEM_TIMEOUT: go to ERROR with err_code = 10.
  - Else cnt++.
- DECODE:
  - Illegal opcode: go to ERROR with err_code = 01.
  - Otherwise go to EXEC.
- EXEC:
  - R-type: alu_op = 00, alu_src = 0, go to WB.
  - LD/ST: alu_op = 10, alu_src = 1, go to MEM.
  - BEQ/BNE: alu_op = 01, alu_src = 0, pc_we = 1. pc_src = 01 if taken (BEQ: alu_zero = 1; BNE: alu_zero = 0), else 00. Go to FETCH.
  - JMP: pc_we = 1, pc_src = 10, go to FETCH.
- MEM:
  - alu_op = 10, alu_src = 1 held throughout.
  - dmem_req = 1; dmem_we = 1 for ST.
  - On dmem_ack: LD goes to WB. ST asserts pc_we = 1, pc_src = 00 in the same cycle and goes to FETCH.
  - Timeout as in FETCH, giving err_code = 11.
- WB:
  - reg_we = 1; mem_to_reg = 1 for LD, 0 otherwise; pc_we = 1, pc_src = 00.
  - Go to FETCH.
- ERROR:
  - All enables and requests are 0.
  - err_code holds; only rst_n exits.
- Timeout counter cnt:
  - Cleared on every state change.
  - Increments only while waiting without ack.
  - An ack in the cycle where cnt == MEM_TIMEOUT wins, so exactly MEM_TIMEOUT+1 request cycles are allowed.
- PC rule: pc_we is asserted exactly once per completed instruction.
- Latency with zero-wait memory:
  - R-type: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - BEQ, BNE, JMP: 3 cycles.

Test Plan:
- Reset then R-type 0010 (ADD), acks immediate -> states 0, 1, 2, 4, 0. alu_op = 00 in EXEC; reg_we = 1, pc_we = 1, pc_src = 00 in WB. Total 4 cycles.
- LD (0000) with dmem_ack delayed 3 cycles -> MEM held 4 cycles with dmem_req = 1, dmem_we = 0, alu_op = 10. Then WB with mem_to_reg = 1, reg_we = 1. ST (0001) -> dmem_we = 1, pc_we in the ack cycle, no WB state.
- BEQ with alu_zero = 1 -> pc_src = 01; alu_zero = 0 -> pc_src = 00. BNE gives the inverse. JMP -> pc_src = 10. Each completes in 3 cycles with alu_op = 01 for branches.
- Opcode 1110 -> DECODE to ERROR, err_code = 01. All outputs held 0 for 20 cycles; rst_n low one edge -> FETCH, err_code = 00.
- MEM_TIMEOUT = 15, imem_ack never asserted -> 16 request cycles, then state = 7, err_code = 10. Ack on the 16th cycle instead -> ir_we = 1, state goes to DECODE.
- rst_n asserted during MEM of an ST -> no pc_we or reg_we on that edge; next state FETCH with imem_req = 1.
